mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: instruction fetch and data load/store share one memory port.
// Data requests win unless they have starved a pending fetch for DATA_BURST grants.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned DATA_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              bus_err
);

  localparam int unsigned WaitW  = $clog2(TIMEOUT + 1);
  localparam int unsigned BurstW = $clog2(DATA_BURST + 1);

  localparam logic [WaitW-1:0]  WaitLast  = WaitW'(TIMEOUT - 1);
  localparam logic [BurstW-1:0] BurstMax  = BurstW'(DATA_BURST);

  typedef enum logic [1:0] {StIdle, StFetch, StData} state_e;

  state_e              state_q, state_d;
  logic [BurstW-1:0]   burst_q, burst_d;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_valid_q, if_valid_d;
  logic                d_valid_q, d_valid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                bus_err_q, bus_err_d;

  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    wait_d      = wait_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    bus_err_d   = bus_err_q;

    unique case (state_q)
      StIdle: begin
        if (d_req && (burst_q < BurstMax)) begin
          state_d     = StData;
          mem_addr_d  = d_addr;
          mem_we_d    = d_we;
          mem_wdata_d = d_wdata;
          wait_d      = '0;
          // Only grants that bypass a waiting fetch count toward starvation.
          burst_d     = if_req ? burst_q + BurstW'(1) : '0;
        end else if (if_req) begin
          state_d     = StFetch;
          mem_addr_d  = if_addr;
          mem_we_d    = 1'b0;
          mem_wdata_d = '0;
          wait_d      = '0;
          burst_d     = '0;
        end else begin
          burst_d = '0;
        end
      end

      StFetch, StData: begin
        if (mem_ready) begin
          state_d = StIdle;
          if (state_q == StFetch) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            d_valid_d = 1'b1;
            if (!mem_we_q) d_rdata_d = mem_rdata;
          end
        end else if (wait_q == WaitLast) begin
          // Abort: complete with zero data and flag the error.
          state_d   = StIdle;
          bus_err_d = 1'b1;
          if (state_q == StFetch) begin
            if_valid_d = 1'b1;
            if_rdata_d = '0;
          end else begin
            d_valid_d = 1'b1;
            if (!mem_we_q) d_rdata_d = '0;
          end
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      burst_q     <= '0;
      wait_q      <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      wait_q      <= wait_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // mem_req decodes the state register so reset drops it without waiting for an edge.
  assign mem_req   = (state_q != StIdle);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign bus_err   = bus_err_q;
  assign stall_if  = if_req & ~if_valid_q;
  assign stall_mem = d_req & ~d_valid_q;

endmodule
